// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler: FSM encoding,
// frame layout and the byte builder used to sequence a 5-byte frame.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACC,
    ST_WAIT_DONE
  } state_t;

  localparam int         FRAME_LEN = 5;
  localparam logic [2:0] IDX_SYNC  = 3'd0;
  localparam logic [2:0] IDX_ID    = 3'd1;
  localparam logic [2:0] IDX_MSB   = 3'd2;
  localparam logic [2:0] IDX_LSB   = 3'd3;
  localparam logic [2:0] IDX_CSUM  = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [2:0]  id,
                                            input logic [15:0] word);
    logic [7:0] id_byte;
    id_byte = {5'b0, id};
    case (idx)
      IDX_SYNC: frame_byte = sync;
      IDX_ID:   frame_byte = id_byte;
      IDX_MSB:  frame_byte = word[15:8];
      IDX_LSB:  frame_byte = word[7:0];
      default:  frame_byte = id_byte ^ word[15:8] ^ word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;
  logic [IDX_W:0]       sum;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[NUM_REQ-1:0];
    any_req = |req;
    off     = '0;
    // Descending scan so the lowest offset from ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    grant_idx = sum[IDX_W-1:0];
    grant     = '0;
    if (any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one byte-wide UART among NUM_REQ 16-bit sources: round-robin grant,
// latch the word, then send SYNC / id / MSB / LSB / checksum via start/busy.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         DATA_WIDTH  = 16,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         ACC_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic [7:0]                    tx_byte,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic                          busy
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam int         TO_W     = $clog2(ACC_TIMEOUT + 1);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [2:0]            id_q, id_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_byte_q, tx_byte_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_req;
  logic [IDX_W:0]        ptr_inc;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    word_d     = word_q;
    to_cnt_d   = to_cnt_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;

    ptr_inc = {1'b0, grant_idx} + (IDX_W + 1)'(1);
    if (ptr_inc == (IDX_W + 1)'(NUM_REQ)) ptr_inc = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          ack_d   = grant;
          word_d  = words[grant_idx];
          id_d    = 3'(grant_idx);
          ptr_d   = ptr_inc[IDX_W-1:0];
          idx_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // Hold off while the UART is still finishing an earlier byte.
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = frame_byte(idx_q, SYNC_BYTE, id_q, word_q[15:0]);
          to_cnt_d   = '0;
          state_d    = ST_WAIT_ACC;
        end
      end
      ST_WAIT_ACC: begin
        if (tx_busy || to_cnt_q == TO_W'(ACC_TIMEOUT - 1)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      id_q       <= '0;
      word_q     <= '0;
      to_cnt_q   <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      word_q     <= word_d;
      to_cnt_q   <= to_cnt_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a behavioural UART and a
// scoreboard of expected acks and frame bytes.
module tb_uart_frame_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*16-1:0] data_in = '0;
  logic [N-1:0]   ack;
  logic [7:0]     tx_byte;
  logic           tx_start;
  logic           tx_busy;
  logic           busy;

  always #5 clk = ~clk;

  uart_frame_scheduler #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (16),
    .SYNC_BYTE   (8'hA5),
    .ACC_TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_byte  (tx_byte),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy     (busy)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [N-1:0] exp_ack_q[$];
  int         busy_len = 10;
  bit         uart_dead = 1'b0;
  bit         auto_clr = 1'b1;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         ack_cnt = 0;
  int         start_cyc[$];

  // UART model: busy from the cycle after an accepted start for busy_len cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start && !uart_dead) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requesters drop req once acknowledged.
  always @(negedge clk) begin
    if (auto_clr) req = req & ~ack;
  end

  always @(negedge clk) begin
    if (ack !== '0) begin
      ack_cnt++;
      check("ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
      if (exp_ack_q.size() != 0) check("ack", 32'(ack), 32'(exp_ack_q.pop_front()));
    end
    if (tx_start === 1'b1) begin
      start_cnt++;
      start_cyc.push_back(cyc);
      check("start_while_busy", 32'(tx_busy), 32'd0);
      check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
    end
  end

  task automatic set_word(input int i, input logic [15:0] w);
    data_in[i*16 +: 16] = w;
  endtask

  task automatic push_frame(input int id, input logic [15:0] w);
    logic [7:0] b1;
    b1 = 8'(id);
    exp_ack_q.push_back(N'(1 << id));
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(b1 ^ w[15:8] ^ w[7:0]);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_end(input string tag, input int n_starts, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && !tx_busy && req == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
    check({tag, "_starts"}, 32'(start_cnt), 32'(n_starts));
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_acks_left"}, 32'(exp_ack_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: source 2 alone, latency ack n+1 / start n+2
    set_word(2, 16'h1234);
    push_frame(2, 16'h1234);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk);
    check("t1_ack_n0", 32'(ack), 32'd0);
    @(negedge clk);
    check("t1_ack_n1", 32'(ack), 32'h4);
    @(negedge clk);
    check("t1_start_n2", 32'(tx_start), 32'd1);
    test_end("t1", 5, 500);

    // T2: simultaneous sources 0 and 2 after reset
    pulse_reset();
    set_word(0, 16'hBEEF);
    push_frame(0, 16'hBEEF);
    push_frame(2, 16'h1234);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0101;
    test_end("t2", 10, 1000);

    // T3: all requests held for five frames, pointer wraps 3 -> 0
    pulse_reset();
    auto_clr = 1'b0;
    busy_len = 3;
    for (int i = 0; i < N; i++) set_word(i, 16'h1111 * 16'(i + 1));
    push_frame(0, 16'h1111);
    push_frame(1, 16'h2222);
    push_frame(2, 16'h3333);
    push_frame(3, 16'h4444);
    push_frame(0, 16'h1111);
    start_cnt = 0;
    ack_cnt = 0;
    @(posedge clk); #1 req = 4'b1111;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ack_cnt >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    req = '0;
    auto_clr = 1'b1;
    check("t3_five_grants", 32'(hit), 32'd1);
    test_end("t3", 25, 500);
    check("t3_ack_count", 32'(ack_cnt), 32'd5);

    // T4: very slow UART
    busy_len = 200;
    set_word(1, 16'h0F5A);
    push_frame(1, 16'h0F5A);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0010;
    test_end("t4", 5, 3000);

    // T5: UART never raises busy, acceptance timeout advances the frame
    busy_len = 10;
    uart_dead = 1'b1;
    set_word(3, 16'h7E81);
    push_frame(3, 16'h7E81);
    start_cnt = 0;
    start_cyc.delete();
    @(posedge clk); #1 req = 4'b1000;
    test_end("t5", 5, 500);
    if (start_cyc.size() >= 2) check("t5_timeout_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd17);
    uart_dead = 1'b0;

    // T6: reset during byte 3, then priority restarts at source 0
    set_word(1, 16'hCAFE);
    exp_ack_q.push_back(4'b0010);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hCA);
    exp_q.push_back(8'hFE);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0010;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (start_cnt >= 4) begin
        hit = 1'b1;
        break;
      end
    end
    check("t6_reached_byte3", 32'(hit), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_tx_start", 32'(tx_start), 32'd0);
    check("t6_rst_tx_byte", 32'(tx_byte), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check("t6_partial_bytes_left", 32'(exp_q.size()), 32'd0);
    set_word(0, 16'h8001);
    push_frame(0, 16'h8001);
    push_frame(1, 16'hCAFE);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0011;
    test_end("t6", 10, 1000);

    // T7: data_in changes one cycle after ack
    set_word(2, 16'h5A5A);
    push_frame(2, 16'h5A5A);
    start_cnt = 0;
    @(posedge clk); #1 req = 4'b0100;
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack == 4'b0100) begin
        hit = 1'b1;
        break;
      end
    end
    check("t7_ack_seen", 32'(hit), 32'd1);
    @(posedge clk); #1 set_word(2, 16'hFFFF);
    test_end("t7", 5, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
